reg_write_arbiter: RTL

Shares the register file's single write port between NREQ writeback requesters (ALU, load, mult/div) using round-robin arbitration. A registered write stage drives the regFile write port. Read data on the Rs/Rt ports is forwarded from that stage so that a write still in flight is visible to readers. The block sits between the writeback sources and `regFile`; the regFile read address and data paths pass through it.

---
 rtl/reg_write_pkg.sv | 27 ++
 rtl/reg_write_arbiter_rr.sv | 68 ++++++
 rtl/reg_write_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reg_write_pkg.sv
// ---------------------------------------------------------------------------
// reg_write_pkg
// Shared constants and types for the register-file write arbiter.
//   AW            : default register address width
//   DW            : default register data width
//   NREQ_DEFAULT  : default number of writeback requesters
//   wr_stage_t    : one write-stage entry {valid, address, data}
//   idx_t(n)      : width of an index able to address n requesters
// ---------------------------------------------------------------------------
package reg_write_pkg;

  localparam int AW           = 5;
  localparam int DW           = 32;
  localparam int NREQ_DEFAULT = 3;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_stage_t;

  // A single requester still needs a 1-bit index, hence the floor of 1.
  function automatic int idx_t(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered priority pointer.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low; pointer returns to NREQ-1 so that
//              requester 0 has first priority, and grants are held off
//   valid    : request vector
//   advance  : a grant was consumed this cycle; pointer moves to the winner
//   grant    : one-hot grant (combinational), never set for an idle request
//   grantIdx : binary index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter
  import reg_write_pkg::*;
#(
  parameter int  NREQ = NREQ_DEFAULT,
  localparam int IW   = idx_t(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grantIdx
);

  logic [IW-1:0]   ptrReg;
  logic [NREQ-1:0] hiMask;
  logic [NREQ-1:0] hiValid;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] grantRaw;
  logic [IW-1:0]   idxChain [NREQ+1];

  genvar gi;

  // Searching from ptr+1 with wrap-around is the same as: prefer the lowest
  // valid index above ptr, otherwise the lowest valid index overall.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign hiMask[gi] = (gi > int'(ptrReg));
    end
  endgenerate

  assign hiValid  = valid & hiMask;
  assign pick     = (|hiValid) ? hiValid : valid;
  // Isolate the lowest set bit of the chosen request set.
  assign grantRaw = pick & ~(pick - 1'b1);

  // One-hot to binary via an OR chain; at most one term is non-zero.
  assign idxChain[0] = '0;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_enc
      assign idxChain[gi+1] = idxChain[gi] | (grantRaw[gi] ? IW'(gi) : '0);
    end
  endgenerate

  // Grants are suppressed while reset is held so nothing is consumed then.
  assign grant    = reset ? grantRaw : '0;
  assign grantIdx = reset ? idxChain[NREQ] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptrReg <= IW'(NREQ - 1);
    end else if (advance) begin
      ptrReg <= grantIdx;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
// Shares the register file's single write port between NREQ writeback
// sources (ALU, load, mult/div). A round-robin arbiter picks one request per
// cycle; the winner is captured in a one-entry write stage that drives the
// regFile write port on the following cycle. Rs/Rt read data is forwarded
// from that stage so a write still in flight is visible to readers.
//
// Ports
//   clk, reset         : clock (rising edge), async active-low reset
//   req_valid/ready    : per-requester handshake, ready is one-hot
//   req_addr, req_data : packed per-requester payload, slice i per requester
//   regWriteEn/Addr/Data : registered regFile write port
//   RsAddr, RtAddr     : read addresses going to the regFile
//   RsData_rf, RtData_rf : raw regFile read data
//   RsData, RtData     : read data after forwarding from the write stage
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int NREQ = reg_write_pkg::NREQ_DEFAULT,
  parameter int DW   = reg_write_pkg::DW,
  parameter int AW   = reg_write_pkg::AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic             regWriteEn,
  output logic [AW-1:0]    regWriteAddr,
  output logic [DW-1:0]    regWriteData,
  input  logic [AW-1:0]    RsAddr,
  input  logic [AW-1:0]    RtAddr,
  input  logic [DW-1:0]    RsData_rf,
  input  logic [DW-1:0]    RtData_rf,
  output logic [DW-1:0]    RsData,
  output logic [DW-1:0]    RtData
);

  import reg_write_pkg::*;

  localparam int IW = idx_t(NREQ);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } stage_t;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grantIdx;
  logic            xfer;
  logic [AW-1:0]   addrArr [NREQ];
  logic [DW-1:0]   dataArr [NREQ];
  logic [AW-1:0]   selAddr;
  logic [DW-1:0]   selData;
  stage_t          stageReg;
  logic            rsHit;
  logic            rtHit;

  genvar gi;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid    (req_valid),
    .advance  (xfer),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  assign req_ready = grant;
  // Grant is already qualified by valid; the AND keeps the transfer
  // definition explicit in terms of the handshake.
  assign xfer      = |(req_valid & grant);

  // -------------------------------------------------------------------------
  // Payload mux
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addrArr[gi] = req_addr[gi*AW +: AW];
      assign dataArr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  assign selAddr = addrArr[grantIdx];
  assign selData = dataArr[grantIdx];

  // -------------------------------------------------------------------------
  // Write stage: reloads every cycle because the write port never stalls.
  // A write to $0 is consumed but leaves the stage invalid; address and data
  // hold whenever nothing new is written so the port outputs stay quiet.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stageReg <= '0;
    end else if (xfer && (selAddr != '0)) begin
      stageReg <= {1'b1, selAddr, selData};
    end else begin
      stageReg.v <= 1'b0;
    end
  end

  assign regWriteEn   = stageReg.v;
  assign regWriteAddr = stageReg.addr;
  assign regWriteData = stageReg.data;

  // -------------------------------------------------------------------------
  // Read forwarding: the staged write reaches the regFile at the next edge,
  // so during the strobe cycle the stage holds the newest value. $0 is never
  // forwarded.
  // -------------------------------------------------------------------------
  assign rsHit  = stageReg.v && (stageReg.addr == RsAddr) && (RsAddr != '0);
  assign rtHit  = stageReg.v && (stageReg.addr == RtAddr) && (RtAddr != '0);
  assign RsData = rsHit ? stageReg.data : RsData_rf;
  assign RtData = rtHit ? stageReg.data : RtData_rf;

endmodule
